// File: rtl/incr_pkg.sv
// Shared types and per-lane arithmetic for the incr_pipe datapath.
package incr_pkg;

    typedef enum logic [1:0] {
        MODE_PASS     = 2'b00,
        MODE_INC_WRAP = 2'b01,
        MODE_INC_SAT  = 2'b10,
        MODE_DEC_WRAP = 2'b11
    } incr_mode_e;

    // Widest lane the helper supports; callers zero-extend into this width (lane width < LANE_MAX_W).
    localparam int unsigned LANE_MAX_W = 256;

    typedef logic [LANE_MAX_W-1:0] lane_t;

    // Returns {ovf, r}; only the low `width` bits of r are meaningful.
    function automatic logic [LANE_MAX_W:0] incr_lane(input lane_t      d,
                                                      input lane_t      step,
                                                      input incr_mode_e mode,
                                                      input int unsigned width);
        logic [LANE_MAX_W:0] sum;
        lane_t               mask;
        lane_t               r;
        logic                carry;
        logic                ovf;
        mask  = (width >= LANE_MAX_W) ? '1 : ((lane_t'(1) << width) - lane_t'(1));
        sum   = {1'b0, d} + {1'b0, step};
        carry = |(sum & ~{1'b0, mask});
        r     = d;
        ovf   = 1'b0;
        case (mode)
            MODE_PASS: begin
                r   = d;
                ovf = 1'b0;
            end
            MODE_INC_WRAP: begin
                r   = sum[LANE_MAX_W-1:0] & mask;
                ovf = carry;
            end
            MODE_INC_SAT: begin
                r   = carry ? mask : sum[LANE_MAX_W-1:0];
                ovf = carry;
            end
            MODE_DEC_WRAP: begin
                r   = (d - step) & mask;
                ovf = (d < step);
            end
            default: begin
                r   = d;
                ovf = 1'b0;
            end
        endcase
        return {ovf, r};
    endfunction

endpackage

// File: rtl/incr_pipe_if.sv
// Beat-level handshake bundle between the stimulus side and incr_pipe.
interface incr_pipe_if #(
    parameter int unsigned WIDTH    = 70,
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned DEPTH    = 2
);
    logic [1:0]                  mode;
    logic                        in_valid;
    logic                        in_ready;
    logic [CHANNELS*WIDTH-1:0]   in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [CHANNELS*WIDTH-1:0]   out_data;
    logic [CHANNELS-1:0]         out_ovf;
    logic [$clog2(DEPTH+1)-1:0]  level;
    logic                        heartbeat;

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, level, heartbeat
    );

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, level, heartbeat
    );
endinterface

// File: rtl/incr_fifo.sv
// Shift-style synchronous FIFO; entry 0 is the registered head.
module incr_fifo #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset_l,
    input  logic                       push_i,
    input  logic [DW-1:0]              push_data_i,
    input  logic                       pop_i,
    output logic [DW-1:0]              head_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;
    logic [LW-1:0]            level_q, level_d;
    logic [LW-1:0]            wr_idx;
    logic                     shift;

    // Shift only when a younger entry exists, so an emptied FIFO keeps the last popped head.
    always_comb begin
        level_d = level_q + LW'(push_i) - LW'(pop_i);
        shift   = pop_i && (level_q > LW'(1));
        wr_idx  = level_q - LW'(pop_i);
        mem_d   = shift ? (mem_q >> DW) : mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (push_i && (LW'(i) == wr_idx)) begin
                mem_d[i] = push_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            mem_q   <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            level_q <= level_d;
        end
    end

    assign head_o  = mem_q[0];
    assign valid_o = (level_q != '0);
    assign level_o = level_q;

endmodule

// File: rtl/incr_pipe.sv
// Multi-lane increment/saturate/decrement stage with output FIFO and heartbeat.
// Optional pop statistics (xfer_cnt, ovf_cnt) when INCR_PIPE_STATS_EN is defined.
module incr_pipe
    import incr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 70,
    parameter int unsigned      CHANNELS = 3,
    parameter logic [WIDTH-1:0] STEP     = WIDTH'(1),
    parameter int unsigned      DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_l,
    incr_pipe_if.slave  bus
`ifdef INCR_PIPE_STATS_EN
    ,
    output logic [31:0] xfer_cnt,
    output logic [31:0] ovf_cnt
`endif
);
    localparam int unsigned LANE_W = WIDTH + 1;
    localparam int unsigned FIFO_W = CHANNELS * LANE_W;
    localparam int unsigned LW     = $clog2(DEPTH + 1);

    logic              push;
    logic              pop;
    logic [FIFO_W-1:0] push_data;
    logic [FIFO_W-1:0] head;
    logic              fifo_valid;
    logic [LW-1:0]     level;
    logic              hb_q, hb_d;

    // A full FIFO still accepts when its head leaves in the same cycle.
    assign pop          = fifo_valid & bus.out_ready;
    assign bus.in_ready = reset_l & ((level < LW'(DEPTH)) | pop);
    assign push         = bus.in_valid & bus.in_ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        logic [LANE_MAX_W:0] res;
        logic                unused_hi;
        assign res = incr_lane(LANE_MAX_W'(bus.in_data[c*WIDTH +: WIDTH]),
                               LANE_MAX_W'(STEP), incr_mode_e'(bus.mode), WIDTH);
        assign unused_hi = ^res[LANE_MAX_W-1:WIDTH];
        assign push_data[c*LANE_W +: LANE_W] = {res[LANE_MAX_W], res[WIDTH-1:0]};
        assign bus.out_data[c*WIDTH +: WIDTH] = head[c*LANE_W +: WIDTH];
        assign bus.out_ovf[c]                  = head[c*LANE_W + WIDTH];
    end

    incr_fifo #(
        .DW    (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset_l     (reset_l),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (fifo_valid),
        .level_o     (level)
    );

    assign bus.out_valid = fifo_valid;
    assign bus.level     = level;

    assign hb_d = ~hb_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            hb_q <= 1'b1;
        end else begin
            hb_q <= hb_d;
        end
    end

    assign bus.heartbeat = hb_q;

`ifdef INCR_PIPE_STATS_EN
    logic [31:0] xfer_q, xfer_d;
    logic [31:0] ovfc_q, ovfc_d;

    always_comb begin
        xfer_d = xfer_q;
        ovfc_d = ovfc_q;
        if (pop) begin
            xfer_d = xfer_q + 32'd1;
            if (|bus.out_ovf) begin
                ovfc_d = ovfc_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            xfer_q <= '0;
            ovfc_q <= '0;
        end else begin
            xfer_q <= xfer_d;
            ovfc_q <= ovfc_d;
        end
    end

    assign xfer_cnt = xfer_q;
    assign ovf_cnt  = ovfc_q;
`endif

endmodule

// File: tb/tb_incr_pipe.sv
// Self-checking bench for incr_pipe (WIDTH=8, CHANNELS=2, STEP=1, DEPTH=2).
module tb_incr_pipe;
    localparam int unsigned W      = 8;
    localparam int unsigned CH     = 2;
    localparam int unsigned D      = 2;
    localparam int unsigned LW     = $clog2(D + 1);
    localparam int unsigned STEP_V = 1;
    localparam int unsigned DW     = CH * W;

    typedef logic [CH+DW-1:0] beat_t;

    localparam logic [1:0]  M_TAB [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd2};
    localparam logic [15:0] D_TAB [6] = '{16'h41FF, 16'h10FF, 16'h1000, 16'hA53C, 16'h0001, 16'hFE7F};
    localparam logic [15:0] R_TAB [6] = '{16'h4200, 16'h11FF, 16'h0FFF, 16'hA53C, 16'hFF00, 16'hFF80};
    localparam logic [1:0]  O_TAB [6] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
    localparam logic [7:0]  EDGE  [4] = '{8'h00, 8'h01, 8'hFE, 8'hFF};

    logic        clk     = 1'b0;
    logic        reset_l = 1'b0;
    int          total   = 0;
    int          bad     = 0;
    beat_t       q[$];
    int unsigned pops     = 0;
    int unsigned ovf_pops = 0;

    always #5 clk = ~clk;

    incr_pipe_if #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D)) bus ();

`ifdef INCR_PIPE_STATS_EN
    logic [31:0] xfer_cnt;
    logic [31:0] ovf_cnt;
`endif

    incr_pipe #(
        .WIDTH    (W),
        .CHANNELS (CH),
        .STEP     (W'(STEP_V)),
        .DEPTH    (D)
    ) dut (
        .clk      (clk),
        .reset_l  (reset_l),
        .bus      (bus)
`ifdef INCR_PIPE_STATS_EN
        ,
        .xfer_cnt (xfer_cnt),
        .ovf_cnt  (ovf_cnt)
`endif
    );

    // Reference: lane arithmetic on plain integers, result packed as {ovf, data}.
    function automatic beat_t model_beat(input logic [1:0] m, input logic [DW-1:0] din);
        int unsigned    lim;
        int unsigned    x;
        int unsigned    y;
        logic [DW-1:0]  r;
        logic [CH-1:0]  o;
        lim = 32'(1) << W;
        r   = '0;
        o   = '0;
        for (int c = 0; c < CH; c++) begin
            x = 32'(din[c*W +: W]);
            case (m)
                2'd0: y = x;
                2'd1: begin
                    y    = (x + STEP_V) % lim;
                    o[c] = (x + STEP_V >= lim);
                end
                2'd2: begin
                    o[c] = (x + STEP_V >= lim);
                    y    = o[c] ? lim - 1 : x + STEP_V;
                end
                default: begin
                    o[c] = (x < STEP_V);
                    y    = (x + lim - STEP_V) % lim;
                end
            endcase
            r[c*W +: W] = W'(y);
        end
        return {o, r};
    endfunction

    // One clock: observe handshakes before the edge, then update the reference queue.
    task automatic tick();
        logic          hi;
        logic          ho;
        logic [1:0]    m;
        logic [DW-1:0] d;
        @(negedge clk);
        hi = bus.in_valid & bus.in_ready;
        ho = bus.out_valid & bus.out_ready;
        m  = bus.mode;
        d  = bus.in_data;
        @(posedge clk);
        #1;
        if (ho && q.size() != 0) begin
            pops++;
            if (q[0][DW +: CH] != '0) ovf_pops++;
            q.delete(0);
        end
        if (hi) q.push_back(model_beat(m, d));
    endtask

    task automatic test_reset();
        reset_l       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.mode      = 2'd1;
        bus.in_data   = 16'hABCD;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.level !== LW'(0)) begin bad++; $display("FAIL reset_level: got %0d want 0", bus.level); end
        total++; if (bus.heartbeat !== 1'b1) begin bad++; $display("FAIL reset_heartbeat: got %b want 1", bus.heartbeat); end
        total++; if (bus.out_data !== '0 || bus.out_ovf !== '0) begin
            bad++; $display("FAIL reset_out_data: got %h/%b want 0/0", bus.out_data, bus.out_ovf);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        reset_l = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bus.heartbeat !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin
                bad++; $display("FAIL heartbeat_%0d: got %b want %b", i, bus.heartbeat, (i % 2 == 0));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_modes();
        for (int i = 0; i < 6; i++) begin
            bus.in_valid  = 1'b1;
            bus.mode      = M_TAB[i];
            bus.in_data   = D_TAB[i];
            bus.out_ready = 1'b1;
            #1;
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mode%0d_in_ready: got %b want 1", i, bus.in_ready); end
            tick();
            bus.in_valid = 1'b0;
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mode%0d_valid: got %b want 1", i, bus.out_valid); end
            total++; if (bus.out_data !== R_TAB[i] || bus.out_ovf !== O_TAB[i]) begin
                bad++; $display("FAIL mode%0d_result: got %h/%b want %h/%b", i, bus.out_data, bus.out_ovf, R_TAB[i], O_TAB[i]);
            end
            tick();
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mode%0d_drain: got %b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_backpressure();
        bus.mode      = 2'd0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h2211;
        tick();
        total++; if (bus.level !== LW'(1) || bus.out_data !== 16'h2211) begin
            bad++; $display("FAIL bp_first: got level %0d data %h want 1 2211", bus.level, bus.out_data);
        end
        bus.in_data = 16'h4433;
        tick();
        total++; if (bus.level !== LW'(2) || bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL bp_full: got level %0d valid %b want 2 1", bus.level, bus.out_valid);
        end
        bus.in_data = 16'h6655;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_full: got %b want 0", bus.in_ready); end
        tick();
        total++; if (bus.level !== LW'(2) || bus.out_data !== 16'h2211) begin
            bad++; $display("FAIL bp_hold: got level %0d data %h want 2 2211", bus.level, bus.out_data);
        end
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_pop: got %b want 1", bus.in_ready); end
        tick();
        total++; if (bus.level !== LW'(2) || bus.out_data !== 16'h4433) begin
            bad++; $display("FAIL bp_push_pop: got level %0d data %h want 2 4433", bus.level, bus.out_data);
        end
        bus.in_valid = 1'b0;
        tick();
        total++; if (bus.level !== LW'(1) || bus.out_data !== 16'h6655) begin
            bad++; $display("FAIL bp_order: got level %0d data %h want 1 6655", bus.level, bus.out_data);
        end
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.level !== LW'(0)) begin
            bad++; $display("FAIL bp_empty: got valid %b level %0d want 0 0", bus.out_valid, bus.level);
        end
    endtask

    task automatic test_random();
        logic exp_rdy;
        int   k;
        for (int n = 0; n < 400; n++) begin
            total++; if (bus.out_valid !== (q.size() != 0)) begin
                bad++; $display("FAIL rnd_valid@%0d: got %b want %b", n, bus.out_valid, (q.size() != 0));
            end
            total++; if (bus.level !== LW'(q.size())) begin
                bad++; $display("FAIL rnd_level@%0d: got %0d want %0d", n, bus.level, q.size());
            end
            if (q.size() != 0) begin
                total++; if ({bus.out_ovf, bus.out_data} !== q[0]) begin
                    bad++; $display("FAIL rnd_head@%0d: got %h want %h", n, {bus.out_ovf, bus.out_data}, q[0]);
                end
            end
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.mode      = 2'($urandom_range(0, 3));
            bus.in_data   = DW'($urandom());
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 1) == 0) begin
                    k = int'($urandom_range(0, 3));
                    bus.in_data[c*W +: W] = EDGE[k];
                end
            end
            bus.out_ready = ($urandom_range(0, 9) < 6);
            #1;
            exp_rdy = (q.size() < D) || (q.size() != 0 && bus.out_ready);
            total++; if (bus.in_ready !== exp_rdy) begin
                bad++; $display("FAIL rnd_in_ready@%0d: got %b want %b", n, bus.in_ready, exp_rdy);
            end
`ifdef INCR_PIPE_STATS_EN
            total++; if (xfer_cnt !== 32'(pops) || ovf_cnt !== 32'(ovf_pops)) begin
                bad++; $display("FAIL rnd_stats@%0d: got %0d/%0d want %0d/%0d", n, xfer_cnt, ovf_cnt, pops, ovf_pops);
            end
`endif
            tick();
        end
    endtask

    task automatic test_reset_mid();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < D + 1; i++) tick();
        bus.out_ready = 1'b0;
        bus.mode      = 2'd1;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'($urandom());
            tick();
        end
        bus.in_valid = 1'b0;
        total++; if (bus.level !== LW'(2) || bus.out_valid !== 1'b1) begin
            bad++; $display("FAIL rm_fill: got level %0d valid %b want 2 1", bus.level, bus.out_valid);
        end
        #2;
        reset_l = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.level !== LW'(0) || bus.in_ready !== 1'b0) begin
            bad++; $display("FAIL rm_async: got valid %b level %0d ready %b want 0 0 0", bus.out_valid, bus.level, bus.in_ready);
        end
        q.delete();
        pops     = 0;
        ovf_pops = 0;
        @(posedge clk);
        @(negedge clk);
        reset_l = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.level !== LW'(0)) begin bad++; $display("FAIL rm_release: got level %0d want 0", bus.level); end
        bus.in_valid  = 1'b1;
        bus.mode      = 2'd3;
        bus.in_data   = 16'h8000;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        total++; if ({bus.out_ovf, bus.out_data} !== {2'b01, 16'h7FFF} || bus.level !== LW'(1)) begin
            bad++; $display("FAIL rm_first_new: got %b/%h level %0d want 01/7fff 1", bus.out_ovf, bus.out_data, bus.level);
        end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rm_drain: got %b want 0", bus.out_valid); end
    endtask

`ifdef INCR_PIPE_STATS_EN
    task automatic test_stats();
        logic [1:0]  sm [5] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd0};
        logic [15:0] sd [5] = '{16'h00FF, 16'h1234, 16'h00FF, 16'h0505, 16'hFFFF};
        reset_l      = 1'b0;
        bus.in_valid = 1'b0;
        q.delete();
        pops     = 0;
        ovf_pops = 0;
        @(negedge clk);
        total++; if (xfer_cnt !== 32'd0 || ovf_cnt !== 32'd0) begin
            bad++; $display("FAIL stats_reset: got %0d/%0d want 0/0", xfer_cnt, ovf_cnt);
        end
        reset_l = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.mode     = sm[i];
            bus.in_data  = sd[i];
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        total++; if (xfer_cnt !== 32'd5 || ovf_cnt !== 32'd2) begin
            bad++; $display("FAIL stats_count: got %0d/%0d want 5/2", xfer_cnt, ovf_cnt);
        end
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.mode      = 2'd0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_modes();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef INCR_PIPE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
